// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, data and tag
// widths, and the record stored per result buffer entry.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_TAG_W  = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  Zero;
    logic                  LessThan;
    logic                  LessThanUnsigned;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_result_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU.
// Ports:
//   a, b             operands
//   ALUControl       operation select (ALU_* codes in alu_pkg)
//   ALUResult        operation result (0 for unassigned codes)
//   Zero             ALUResult == 0
//   LessThan         signed a < b
//   LessThanUnsigned unsigned a < b
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        ALUControl,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero,
  output logic              LessThan,
  output logic              LessThanUnsigned
);

  logic [4:0] shamt;

  assign shamt            = b[4:0];
  assign LessThan         = $signed(a) < $signed(b);
  assign LessThanUnsigned = a < b;
  assign Zero             = (ALUResult == '0);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD:  ALUResult = a + b;
      ALU_SUB:  ALUResult = a - b;
      ALU_AND:  ALUResult = a & b;
      ALU_OR:   ALUResult = a | b;
      ALU_XOR:  ALUResult = a ^ b;
      ALU_SLL:  ALUResult = a << shamt;
      ALU_SRL:  ALUResult = a >> shamt;
      ALU_SRA:  ALUResult = $signed(a) >>> shamt;
      ALU_SLT:  ALUResult = {{(DATA_W-1){1'b0}}, LessThan};
      ALU_SLTU: ALUResult = {{(DATA_W-1){1'b0}}, LessThanUnsigned};
      default:  ALUResult = '0;
    endcase
  end

endmodule

// File: rtl/result_fifo2.sv
// Two-entry circular FIFO of alu_result_t records.
// Ports:
//   clk, reset  clock, asynchronous active-high reset (empties the FIFO)
//   push, din   write din into the tail slot (ignored when full)
//   pop         retire the head slot (ignored when empty)
//   dout        head slot contents, held while not popped
//   not_empty   at least one entry held
//   full        DEPTH entries held
//   occupancy   entries held (0..2)
module result_fifo2
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  alu_result_t din,
  input  logic        pop,
  output alu_result_t dout,
  output logic        not_empty,
  output logic        full,
  output logic [1:0]  occupancy
);

  alu_result_t mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        do_push;
  logic        do_pop;

  assign full      = (count_q == 2'(DEPTH));
  assign not_empty = (count_q != 2'd0);
  assign occupancy = count_q;
  assign do_push   = push & ~full;
  assign do_pop    = pop & not_empty;
  assign dout      = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: evaluates each accepted op with the combinational ALU and
// buffers result, flags and tag in a 2-entry FIFO feeding a valid/ready
// result stream.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_ready depends on state only
//   in_a, in_b            operands
//   in_ALUControl, in_tag operation select and destination tag
//   out_valid/out_ready   downstream handshake for the head entry
//   out_ALUResult, out_Zero, out_LessThan, out_LessThanUnsigned, out_tag
//                         head entry payload
//   occupancy             entries buffered (0..2)
//   op_count              ops accepted since reset (wraps)
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned TAG_W  = ALU_TAG_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_ALUControl,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ALUResult,
  output logic              out_Zero,
  output logic              out_LessThan,
  output logic              out_LessThanUnsigned,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy,
  output logic [31:0]       op_count
);

  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_lt;
  logic              alu_ltu;
  logic              push;
  logic              pop;
  logic              full;
  alu_result_t       fifo_din;
  alu_result_t       fifo_dout;
  logic [31:0]       op_count_q;

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a                (in_a),
    .b                (in_b),
    .ALUControl       (in_ALUControl),
    .ALUResult        (alu_result),
    .Zero             (alu_zero),
    .LessThan         (alu_lt),
    .LessThanUnsigned (alu_ltu)
  );

  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_comb begin
    fifo_din                  = '0;
    fifo_din.result           = alu_result;
    fifo_din.Zero             = alu_zero;
    fifo_din.LessThan         = alu_lt;
    fifo_din.LessThanUnsigned = alu_ltu;
    fifo_din.tag              = in_tag;
  end

  result_fifo2 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .din       (fifo_din),
    .pop       (pop),
    .dout      (fifo_dout),
    .not_empty (out_valid),
    .full      (full),
    .occupancy (occupancy)
  );

  assign out_ALUResult        = fifo_dout.result;
  assign out_Zero             = fifo_dout.Zero;
  assign out_LessThan         = fifo_dout.LessThan;
  assign out_LessThanUnsigned = fifo_dout.LessThanUnsigned;
  assign out_tag              = fifo_dout.tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count_q <= '0;
    end else if (push) begin
      op_count_q <= op_count_q + 32'd1;
    end
  end

  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: ALU vector table plus backpressure,
// streaming, reset-while-full and op_count wrap sequences.
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_ALUControl;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ALUResult;
  logic        out_Zero;
  logic        out_LessThan;
  logic        out_LessThanUnsigned;
  logic [4:0]  out_tag;
  logic [1:0]  occupancy;
  logic [31:0] op_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_cnt;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        lt;
    logic        ltu;
  } vec_t;

  vec_t vecs [13];

  alu_exec_stage #(
    .DATA_W (32),
    .TAG_W  (5),
    .DEPTH  (2)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_a                 (in_a),
    .in_b                 (in_b),
    .in_ALUControl        (in_ALUControl),
    .in_tag               (in_tag),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_ALUResult        (out_ALUResult),
    .out_Zero             (out_Zero),
    .out_LessThan         (out_LessThan),
    .out_LessThanUnsigned (out_LessThanUnsigned),
    .out_tag              (out_tag),
    .occupancy            (occupancy),
    .op_count             (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    in_valid      = 1'b1;
    in_ALUControl = c;
    in_a          = a;
    in_b          = b;
    in_tag        = t;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    in_ALUControl = 'x;
    in_a          = 'x;
    in_b          = 'x;
    in_tag        = 'x;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({pfx, "_in_ready"},  32'(in_ready),  32'd1);
    chk({pfx, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({pfx, "_op_count"},  op_count,       32'd0);
  endtask

  // Push one op with out_ready=1 and check it at the head one cycle later.
  task automatic one_op(input string name, input vec_t v, input logic [4:0] t);
    @(negedge clk);
    drive(v.ctrl, v.a, v.b, t);
    @(posedge clk);
    #1 idle();
    exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
    chk({name, "_valid"},  32'(out_valid),            32'd1);
    chk({name, "_result"}, out_ALUResult,             v.res);
    chk({name, "_zero"},   32'(out_Zero),             32'(v.z));
    chk({name, "_lt"},     32'(out_LessThan),         32'(v.lt));
    chk({name, "_ltu"},    32'(out_LessThanUnsigned), 32'(v.ltu));
    chk({name, "_tag"},    32'(out_tag),              32'(t));
    chk({name, "_count"},  op_count,                  exp_cnt);
  endtask

  initial begin
    vecs[0]  = '{ALU_ADD,  32'd5,         32'd7,         32'd12,        1'b0, 1'b1, 1'b1};
    vecs[1]  = '{ALU_SUB,  32'd9,         32'd9,         32'd0,         1'b1, 1'b0, 1'b0};
    vecs[2]  = '{ALU_SLT,  32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b1, 1'b0};
    vecs[3]  = '{ALU_SLTU, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b1, 1'b0};
    vecs[4]  = '{ALU_AND,  32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0, 1'b1, 1'b1};
    vecs[5]  = '{ALU_OR,   32'h0000000F,  32'h000000F0,  32'h000000FF,  1'b0, 1'b1, 1'b1};
    vecs[6]  = '{ALU_XOR,  32'h12345678,  32'h12345678,  32'd0,         1'b1, 1'b0, 1'b0};
    vecs[7]  = '{ALU_SLL,  32'd1,         32'h00000024,  32'h00000010,  1'b0, 1'b1, 1'b1};
    vecs[8]  = '{ALU_SRL,  32'h80000000,  32'd31,        32'd1,         1'b0, 1'b1, 1'b0};
    vecs[9]  = '{ALU_SRA,  32'h80000000,  32'd4,         32'hF8000000,  1'b0, 1'b1, 1'b0};
    vecs[10] = '{ALU_ADD,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b1, 1'b0};
    vecs[11] = '{4'b1111,  32'd3,         32'd4,         32'd0,         1'b1, 1'b1, 1'b1};
    vecs[12] = '{ALU_SUB,  32'd3,         32'd5,         32'hFFFFFFFE,  1'b0, 1'b1, 1'b1};

    reset     = 1'b1;
    out_ready = 1'b1;
    exp_cnt   = '0;
    idle();
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    chk("rst_result", out_ALUResult, 32'd0);
    chk("rst_tag",    32'(out_tag),  32'd0);
    chk("rst_flags",  32'({out_Zero, out_LessThan, out_LessThanUnsigned}), 32'd0);
    reset = 1'b0;

    // ALU vector table, one op at a time
    for (int i = 0; i < 13; i++) begin
      one_op($sformatf("vec%0d", i), vecs[i], 5'(i + 3));
    end
    @(negedge clk);
    chk("vec_drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: third op is refused, head payload stays stable
    out_ready = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd1, 5'd10);
    @(posedge clk);
    @(negedge clk);
    chk("bp_occ1",   32'(occupancy), 32'd1);
    chk("bp_rdy1",   32'(in_ready),  32'd1);
    drive(ALU_ADD, 32'd2, 32'd2, 5'd11);
    @(posedge clk);
    @(negedge clk);
    chk("bp_occ2",   32'(occupancy), 32'd2);
    chk("bp_rdy2",   32'(in_ready),  32'd0);
    drive(ALU_ADD, 32'd3, 32'd3, 5'd12);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_result", out_ALUResult, 32'd2);
      chk("bp_hold_tag",    32'(out_tag),  32'd10);
      chk("bp_hold_occ",    32'(occupancy), 32'd2);
    end
    exp_cnt = exp_cnt + 32'd2;
    chk("bp_count", op_count, exp_cnt);
    idle();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_drain_result", out_ALUResult, 32'd4);
    chk("bp_drain_tag",    32'(out_tag),  32'd11);
    chk("bp_drain_occ",    32'(occupancy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_empty_valid", 32'(out_valid), 32'd0);
    chk("bp_empty_occ",   32'(occupancy), 32'd0);

    // Streaming at full throughput: push and pop every cycle at occupancy 1
    for (int i = 0; i < 20; i++) begin
      drive(ALU_ADD, 32'(i), 32'd100, 5'(i));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("st%0d_valid", i),  32'(out_valid),  32'd1);
      chk($sformatf("st%0d_occ", i),    32'(occupancy),  32'd1);
      chk($sformatf("st%0d_result", i), out_ALUResult,   32'(i + 100));
      chk($sformatf("st%0d_tag", i),    32'(out_tag),    32'(i));
    end
    idle();
    exp_cnt = exp_cnt + 32'd20;
    chk("st_count", op_count, exp_cnt);
    @(posedge clk);
    @(negedge clk);
    chk("st_empty_occ", 32'(occupancy), 32'd0);

    // Reset while full
    out_ready = 1'b0;
    drive(ALU_OR, 32'd1, 32'd2, 5'd20);
    @(posedge clk);
    @(negedge clk);
    drive(ALU_OR, 32'd4, 32'd8, 5'd21);
    @(posedge clk);
    @(negedge clk);
    idle();
    chk("rf_pre_occ", 32'(occupancy), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk_reset_state("rf");
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = '0;
    one_op("rf_again", vecs[0], 5'd3);

    // op_count wrap
    @(negedge clk);
    force dut.op_count_q = 32'hFFFFFFFF;
    #1 release dut.op_count_q;
    #1 chk("wrap_pre", op_count, 32'hFFFFFFFF);
    exp_cnt = 32'hFFFFFFFF;
    one_op("wrap", vecs[11], 5'd31);
    chk("wrap_zero", op_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
